// File: rtl/tone_pkg.sv
// Shared types and constants for the tone_gen sequencer: FSM states and harmonic presets.
package tone_pkg;

  localparam int PRESET_A_BITS = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_OUT = 2'd1,
    SWAP     = 2'd2,
    FADE_IN  = 2'd3
  } tc_state_t;

  typedef struct packed {
    logic [PRESET_A_BITS-1:0] a16;
    logic [PRESET_A_BITS-1:0] a8;
    logic [PRESET_A_BITS-1:0] a5;
    logic [PRESET_A_BITS-1:0] a4;
  } preset_t;

  localparam preset_t PRESET_0 = '{a16: 3'd7, a8: 3'd0, a5: 3'd0, a4: 3'd0};
  localparam preset_t PRESET_1 = '{a16: 3'd7, a8: 3'd4, a5: 3'd2, a4: 3'd1};
  localparam preset_t PRESET_2 = '{a16: 3'd4, a8: 3'd7, a5: 3'd0, a4: 3'd3};
  localparam preset_t PRESET_3 = '{a16: 3'd0, a8: 3'd7, a5: 3'd5, a4: 3'd7};

  // Packed so PRESETS[i] selects preset i directly.
  localparam preset_t [3:0] PRESETS = {PRESET_3, PRESET_2, PRESET_1, PRESET_0};

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks, first tick
// TICK_DIV cycles after reset release.
module tick_gen #(
  parameter int TICK_DIV = 1024
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/tone_ctrl.sv
// Sequencer in front of tone_gen: portamento glide of freq toward the latest
// pitch measurement, and click-free preset swaps via a fade of the output gain.
module tone_ctrl
  import tone_pkg::*;
#(
  parameter int F_BITS    = 12,
  parameter int A_BITS    = 3,
  parameter int GAIN_BITS = 6,
  parameter int TICK_DIV  = 1024,
  parameter int GLIDE_SH  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [F_BITS-1:0]    meas_freq,
  input  logic                 meas_valid,
  input  logic [1:0]           preset_sel,
  input  logic                 preset_req,
  output logic                 preset_ack,
  output logic                 busy,
  output logic [F_BITS-1:0]    freq,
  output logic [A_BITS-1:0]    a16,
  output logic [A_BITS-1:0]    a8,
  output logic [A_BITS-1:0]    a5,
  output logic [A_BITS-1:0]    a4,
  output logic [GAIN_BITS-1:0] gain
);

  localparam logic [GAIN_BITS-1:0] GMAX    = '1;
  localparam logic [GAIN_BITS-1:0] GMAX_M1 = GAIN_BITS'(GMAX - 1'b1);

  logic tick;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // ---------------- glide datapath ----------------
  logic [F_BITS-1:0]       freq_reg, freq_next;
  logic [F_BITS-1:0]       target_reg;
  logic signed [F_BITS:0]  diff;
  logic [F_BITS-1:0]       mag;
  logic [F_BITS-1:0]       shifted;
  logic [F_BITS-1:0]       glide_step;

  always_comb begin
    diff       = $signed({1'b0, target_reg}) - $signed({1'b0, freq_reg});
    // |diff| never exceeds 2**F_BITS-1, so the truncation is lossless.
    mag        = F_BITS'(diff[F_BITS] ? -diff : diff);
    shifted    = mag >> GLIDE_SH;
    glide_step = (shifted == '0) ? F_BITS'(1) : shifted;
    freq_next  = freq_reg;
    if (tick && (diff != '0)) begin
      if (diff[F_BITS]) begin
        freq_next = freq_reg - glide_step;
      end else begin
        freq_next = freq_reg + glide_step;
      end
    end
  end

  // The glide reads the pre-update target, so a coincident meas_valid only
  // influences the following tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      freq_reg   <= '0;
      target_reg <= '0;
    end else begin
      freq_reg <= freq_next;
      if (meas_valid) begin
        target_reg <= meas_freq;
      end
    end
  end

  // ---------------- preset FSM ----------------
  tc_state_t            state_reg, state_next;
  logic [GAIN_BITS-1:0] gain_reg, gain_next;
  logic [1:0]           cur_sel_reg, cur_sel_next;
  logic [1:0]           req_sel_reg, req_sel_next;
  preset_t              amp_reg, amp_next;
  logic                 ack_reg, ack_next;
  logic                 busy_reg;
  logic                 from_swap_reg, from_swap_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= FADE_IN;
      gain_reg      <= '0;
      cur_sel_reg   <= 2'd0;
      req_sel_reg   <= 2'd0;
      amp_reg       <= PRESETS[0];
      ack_reg       <= 1'b0;
      busy_reg      <= 1'b1;
      from_swap_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      gain_reg      <= gain_next;
      cur_sel_reg   <= cur_sel_next;
      req_sel_reg   <= req_sel_next;
      amp_reg       <= amp_next;
      ack_reg       <= ack_next;
      busy_reg      <= (state_next != IDLE);
      from_swap_reg <= from_swap_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    gain_next      = gain_reg;
    cur_sel_next   = cur_sel_reg;
    req_sel_next   = req_sel_reg;
    amp_next       = amp_reg;
    ack_next       = 1'b0;
    from_swap_next = from_swap_reg;
    case (state_reg)
      IDLE: begin
        if (preset_req) begin
          if (preset_sel == cur_sel_reg) begin
            ack_next = 1'b1;
          end else begin
            req_sel_next = preset_sel;
            state_next   = (gain_reg == '0) ? SWAP : FADE_OUT;
          end
        end
      end
      FADE_OUT: begin
        if (tick) begin
          if (gain_reg == '0) begin
            state_next = SWAP;
          end else begin
            gain_next = gain_reg - 1'b1;
          end
        end
      end
      SWAP: begin
        amp_next       = PRESETS[req_sel_reg];
        cur_sel_next   = req_sel_reg;
        from_swap_next = 1'b1;
        state_next     = FADE_IN;
      end
      FADE_IN: begin
        // Leave on the same edge that lands gain on GMAX; the soft start
        // after reset has from_swap clear and so never acks.
        if (gain_reg == GMAX) begin
          state_next     = IDLE;
          ack_next       = from_swap_reg;
          from_swap_next = 1'b0;
        end else if (tick) begin
          gain_next = gain_reg + 1'b1;
          if (gain_reg == GMAX_M1) begin
            state_next     = IDLE;
            ack_next       = from_swap_reg;
            from_swap_next = 1'b0;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign freq       = freq_reg;
  assign gain       = gain_reg;
  assign preset_ack = ack_reg;
  assign busy       = busy_reg;
  assign a16        = A_BITS'(amp_reg.a16);
  assign a8         = A_BITS'(amp_reg.a8);
  assign a5         = A_BITS'(amp_reg.a5);
  assign a4         = A_BITS'(amp_reg.a4);

endmodule
